// File: rtl/uart_cmd_decoder.sv
// 8N1 UART receiver that decodes single-byte ASCII drive commands into held control levels,
// with a link watchdog that forces failsafe and drops motion when commands stop arriving.
module uart_cmd_decoder #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int FAILSAFE_MS = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic fwd_out,
  output logic bwd_out,
  output logic left_out,
  output logic right_out,
  output logic stoplight_out,
  output logic stopsign_out,
  output logic failsafe_out,
  output logic buzzer_out,
  output logic cmd_valid,
  output logic frame_err
);

  localparam int     CPB   = CLK_HZ / BAUD;
  localparam int     HALF  = CPB / 2;
  localparam int     CNT_W = $clog2(CPB + 1);
  localparam longint WD_L  = longint'(FAILSAFE_MS) * longint'(CLK_HZ / 1000);
  localparam int     WD_W  = (WD_L < 2) ? 1 : $clog2(WD_L + 1);
  localparam logic [WD_W-1:0] WD = WD_W'(WD_L);

  if (WD_L > 64'd4294967295 || WD_L < 1) begin : g_wd_range
    $error("uart_cmd_decoder: watchdog reload must be in 1 .. 2^32-1 cycles");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  rx_state_e         state_q;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              byte_vld_q;
  logic              frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        // A falling edge is required, so after a bad stop bit the line must go high first.
        IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_sync_q) byte_vld_q  <= 1'b1;
            else           frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic            fwd_q, bwd_q, left_q, right_q, stoplight_q, stopsign_q, failsafe_q, buzzer_q;
  logic            fwd_d, bwd_d, left_d, right_d, stoplight_d, stopsign_d, failsafe_d, buzzer_d;
  logic            cmd_valid_q, cmd_valid_d, hit;
  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    fwd_d       = fwd_q;
    bwd_d       = bwd_q;
    left_d      = left_q;
    right_d     = right_q;
    stoplight_d = stoplight_q;
    stopsign_d  = stopsign_q;
    buzzer_d    = buzzer_q;
    failsafe_d  = failsafe_q;
    wd_d        = wd_q;
    hit         = 1'b0;
    if (byte_vld_q) begin
      hit = 1'b1;
      case (shift_q)
        8'h46: begin fwd_d = 1'b1; bwd_d = 1'b0; end
        8'h42: begin bwd_d = 1'b1; fwd_d = 1'b0; end
        8'h4C: begin left_d = 1'b1; right_d = 1'b0; end
        8'h52: begin right_d = 1'b1; left_d = 1'b0; end
        8'h43: begin left_d = 1'b0; right_d = 1'b0; end
        8'h58: begin fwd_d = 1'b0; bwd_d = 1'b0; left_d = 1'b0; right_d = 1'b0; end
        8'h54: stoplight_d = 1'b1;
        8'h74: stoplight_d = 1'b0;
        8'h50: stopsign_d  = 1'b1;
        8'h70: stopsign_d  = 1'b0;
        8'h48: buzzer_d    = 1'b1;
        8'h68: buzzer_d    = 1'b0;
        default: hit = 1'b0;
      endcase
    end
    cmd_valid_d = hit;
    // A command arriving on the expiry cycle pre-empts the timeout entirely.
    if (hit) begin
      wd_d       = WD;
      failsafe_d = 1'b0;
    end else if (!failsafe_q) begin
      if (wd_q <= WD_W'(1)) begin
        failsafe_d = 1'b1;
        fwd_d      = 1'b0;
        bwd_d      = 1'b0;
        left_d     = 1'b0;
        right_d    = 1'b0;
      end
      if (wd_q != '0) wd_d = wd_q - WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q       <= 1'b0;
      bwd_q       <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      stoplight_q <= 1'b0;
      stopsign_q  <= 1'b0;
      buzzer_q    <= 1'b0;
      failsafe_q  <= 1'b1;
      cmd_valid_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      fwd_q       <= fwd_d;
      bwd_q       <= bwd_d;
      left_q      <= left_d;
      right_q     <= right_d;
      stoplight_q <= stoplight_d;
      stopsign_q  <= stopsign_d;
      buzzer_q    <= buzzer_d;
      failsafe_q  <= failsafe_d;
      cmd_valid_q <= cmd_valid_d;
      wd_q        <= wd_d;
    end
  end

  assign fwd_out       = fwd_q;
  assign bwd_out       = bwd_q;
  assign left_out      = left_q;
  assign right_out     = right_q;
  assign stoplight_out = stoplight_q;
  assign stopsign_out  = stopsign_q;
  assign failsafe_out  = failsafe_q;
  assign buzzer_out    = buzzer_q;
  assign cmd_valid     = cmd_valid_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder at CPB=10, watchdog reload 1000 cycles.
module tb_uart_cmd_decoder;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic fwd_out, bwd_out, left_out, right_out;
  logic stoplight_out, stopsign_out, failsafe_out, buzzer_out;
  logic cmd_valid, frame_err;
  logic [7:0] outs;

  int   cyc = 0, tests = 0, failed = 0;
  int   cv_cnt = 0, fe_cnt = 0, cv_cyc = 0, t_start = 0, fs_cyc = 0, lat = 0;
  logic both_seen = 1'b0;
  logic bwd_before = 1'b0;

  uart_cmd_decoder #(.CLK_HZ(1_000_000), .BAUD(100_000), .FAILSAFE_MS(1)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .fwd_out(fwd_out), .bwd_out(bwd_out), .left_out(left_out), .right_out(right_out),
    .stoplight_out(stoplight_out), .stopsign_out(stopsign_out),
    .failsafe_out(failsafe_out), .buzzer_out(buzzer_out),
    .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  // {fwd, bwd, left, right, stoplight, stopsign, failsafe, buzzer}
  assign outs = {fwd_out, bwd_out, left_out, right_out,
                 stoplight_out, stopsign_out, failsafe_out, buzzer_out};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_cnt = cv_cnt + 1;
      cv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (cmd_valid && frame_err) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int abort_bit);
    t_start = cyc;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    if (!stop) begin
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: bench did not finish, observed cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'h02);
    check("reset_pulses", 32'({cmd_valid, frame_err}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send_byte(8'h46, 1'b1, -1);
    lat = cv_cyc - t_start;
    check("F_latency_in_98_100", 32'(lat >= 98 && lat <= 100), 32'h1);
    check("F_cmd_count", 32'(cv_cnt), 32'd1);
    check("F_outs", 32'(outs), 32'h80);

    send_byte(8'h46, 1'b1, -1);
    send_byte(8'h4C, 1'b1, -1);
    send_byte(8'h42, 1'b1, -1);
    send_byte(8'h43, 1'b1, -1);
    check("FLBC_cmd_count", 32'(cv_cnt), 32'd5);
    check("FLBC_outs", 32'(outs), 32'h40);

    send_byte(8'h54, 1'b1, -1);
    send_byte(8'h48, 1'b1, -1);
    check("TH_cmd_count", 32'(cv_cnt), 32'd7);
    check("TH_outs", 32'(outs), 32'h49);

    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (failsafe_out) begin
        fs_cyc = cyc;
        break;
      end
      bwd_before = bwd_out;
    end
    check("wd_expiry_delay", 32'(fs_cyc - cv_cyc), 32'd1000);
    check("wd_motion_before_expiry", 32'(bwd_before), 32'h1);
    check("wd_outs_after", 32'(outs), 32'h0B);
    @(posedge clk);
    #1;

    send_byte(8'h46, 1'b0, -1);
    check("ferr_count", 32'(fe_cnt), 32'd1);
    check("ferr_no_cmd", 32'(cv_cnt), 32'd7);
    check("ferr_outs", 32'(outs), 32'h0B);

    send_byte(8'h58, 1'b1, -1);
    check("X_cmd_count", 32'(cv_cnt), 32'd8);
    check("X_outs", 32'(outs), 32'h09);

    send_byte(8'h50, 1'b1, -1);
    check("P_outs", 32'(outs), 32'h0D);
    send_byte(8'h5A, 1'b1, -1);
    check("unknown_cmd_count", 32'(cv_cnt), 32'd9);
    check("unknown_outs", 32'(outs), 32'h0D);
    send_byte(8'h74, 1'b1, -1);
    send_byte(8'h68, 1'b1, -1);
    send_byte(8'h70, 1'b1, -1);
    check("thp_cmd_count", 32'(cv_cnt), 32'd12);
    check("thp_outs", 32'(outs), 32'h00);

    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_no_ferr", 32'(fe_cnt), 32'd1);
    check("glitch_no_cmd", 32'(cv_cnt), 32'd12);
    check("glitch_fsm_idle", 32'(int'(dut.state_q)), 32'd0);

    send_byte(8'h52, 1'b1, 4);
    @(negedge clk);
    check("midbyte_reset_outs", 32'(outs), 32'h02);
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h52, 1'b1, -1);
    check("R_after_reset_outs", 32'(outs), 32'h10);
    check("R_after_reset_cmd_count", 32'(cv_cnt), 32'd13);
    check("never_cmd_and_ferr", 32'(both_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
